// File: rtl/instr_fill_loader_pkg.sv
// Shared definitions for the instruction RAM fill loader.
package instr_fill_loader_pkg;

   localparam int DEPTH          = 64;
   localparam int ADDR_W         = 6;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } ld_state_e;

endpackage

// File: rtl/instr_fill_loader.sv
// Instruction RAM fill master: packs a byte stream big-endian into 32-bit
// words and writes them to consecutive word indices of a RAM that has no
// write enable. The core is held in reset until the image is loaded.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset; core held in reset, RAM[0] rewritten with 0
// COLLECT | accepting bytes into the pack register
// WRITE   | one cycle; RAM captures the registered addr/data pair
// DONE    | load finished (or N=0); core released, last pair held
module instr_fill_loader
   import instr_fill_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start_LD0,
   input  logic [6:0]  NumWords_LD0,
   input  logic        ByteVld_LD0,
   input  logic [7:0]  ByteData_LD0,
   output logic        ByteRdy_LD0,
   output logic [31:0] IntrAddr_FL0,
   output logic [31:0] IntrFill_FL0,
   output logic        CoreReset_LD0,
   output logic        Busy_LD0,
   output logic        Done_LD0,
   output logic [31:0] Sum_LD0
);

   localparam logic [6:0] DEPTH_W = 7'(DEPTH);
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   ld_state_e   state_q;
   logic [1:0]  byte_cnt_q;
   logic [6:0]  word_cnt_q;
   logic [6:0]  num_q;
   logic [23:0] pack_q;
   logic [31:0] addr_q;
   logic [31:0] fill_q;
   logic [31:0] sum_q;
   logic        rdy_q;
   logic        core_rst_q;
   logic        busy_q;
   logic        done_q;

   logic [6:0]  num_sat_d;
   logic        xfer;

   // Word count request clamps to RAM depth so the index never overruns.
   always_comb begin
      num_sat_d = (NumWords_LD0 > DEPTH_W) ? DEPTH_W : NumWords_LD0;
      xfer      = ByteVld_LD0 && rdy_q;
   end

   // Load sequencer; every output is registered so the RAM never sees a
   // mixed old-address/new-data pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         num_q      <= '0;
         pack_q     <= '0;
         addr_q     <= '0;
         fill_q     <= '0;
         sum_q      <= '0;
         rdy_q      <= 1'b0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (Start_LD0) begin
                  if (num_sat_d == '0) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     core_rst_q <= 1'b0;
                  end else begin
                     state_q    <= S_COLLECT;
                     num_q      <= num_sat_d;
                     sum_q      <= '0;
                     byte_cnt_q <= '0;
                     word_cnt_q <= '0;
                     core_rst_q <= 1'b1;
                     rdy_q      <= 1'b1;
                     busy_q     <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (xfer) begin
                  pack_q     <= {pack_q[15:0], ByteData_LD0};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == LAST_BYTE) begin
                     fill_q  <= {pack_q, ByteData_LD0};
                     addr_q  <= {{(32 - ADDR_W){1'b0}}, word_cnt_q[ADDR_W-1:0]};
                     rdy_q   <= 1'b0;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               sum_q      <= sum_q + fill_q;
               word_cnt_q <= word_cnt_q + 7'd1;
               if (word_cnt_q + 7'd1 == num_q) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  core_rst_q <= 1'b0;
               end else begin
                  state_q <= S_COLLECT;
                  rdy_q   <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ByteRdy_LD0   = rdy_q;
   assign IntrAddr_FL0  = addr_q;
   assign IntrFill_FL0  = fill_q;
   assign CoreReset_LD0 = core_rst_q;
   assign Busy_LD0      = busy_q;
   assign Done_LD0      = done_q;
   assign Sum_LD0       = sum_q;

endmodule

// File: tb/tb_instr_fill_loader.sv
// Bench for instr_fill_loader: a behavioural RAM plus a reference model
// that derives expected words and sums straight from the byte stream.
module tb_instr_fill_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start_LD0;
   logic [6:0]  NumWords_LD0;
   logic        ByteVld_LD0;
   logic [7:0]  ByteData_LD0;
   logic        ByteRdy_LD0;
   logic [31:0] IntrAddr_FL0;
   logic [31:0] IntrFill_FL0;
   logic        CoreReset_LD0;
   logic        Busy_LD0;
   logic        Done_LD0;
   logic [31:0] Sum_LD0;

   int n_pass = 0;
   int n_chk  = 0;

   logic [31:0] ram [64];
   logic [63:0] last_pair;
   int          pair_changes = 0;
   int          done_pulses  = 0;

   instr_fill_loader dut (
      .clk          (clk),
      .reset        (reset),
      .Start_LD0    (Start_LD0),
      .NumWords_LD0 (NumWords_LD0),
      .ByteVld_LD0  (ByteVld_LD0),
      .ByteData_LD0 (ByteData_LD0),
      .ByteRdy_LD0  (ByteRdy_LD0),
      .IntrAddr_FL0 (IntrAddr_FL0),
      .IntrFill_FL0 (IntrFill_FL0),
      .CoreReset_LD0(CoreReset_LD0),
      .Busy_LD0     (Busy_LD0),
      .Done_LD0     (Done_LD0),
      .Sum_LD0      (Sum_LD0)
   );

   always #5 clk = ~clk;

   // RAM without write enable: captures the presented pair on every edge.
   always @(posedge clk) ram[IntrAddr_FL0[5:0]] <= IntrFill_FL0;

   // Count distinct address/data pairs presented and Done pulses.
   always @(negedge clk) begin
      if ({IntrAddr_FL0, IntrFill_FL0} !== last_pair) pair_changes++;
      last_pair = {IntrAddr_FL0, IntrFill_FL0};
      if (Done_LD0) done_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int n);
      Start_LD0    = 1'b1;
      NumWords_LD0 = 7'(n);
      tick();
      Start_LD0    = 1'b0;
   endtask

   // Offer one byte until accepted; returns 0 if the loader never took it.
   task automatic push_byte(input logic [7:0] b, output bit ok);
      int t = 0;
      ok = 0;
      ByteVld_LD0  = 1'b1;
      ByteData_LD0 = b;
      while (t < 50 && !ok) begin
         if (ByteRdy_LD0) ok = 1;
         tick();
         t++;
      end
      ByteVld_LD0 = 1'b0;
      if (!ok) begin
         n_chk++;
         $display("FAIL byte_accept: ByteRdy never rose (waited %0d cycles)", t);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [7:0] q[$], input int i);
      return {q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]};
   endfunction

   task automatic wait_done(output bit ok);
      int t = 0;
      ok = 0;
      while (t < 20 && !ok) begin
         if (Done_LD0) ok = 1;
         else begin tick(); t++; end
      end
      n_chk++;
      if (!ok) $display("FAIL done_wait: Done never seen after %0d cycles", t);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_chk++;
         if ({CoreReset_LD0, ByteRdy_LD0, Busy_LD0, Done_LD0} !== 4'b1000 ||
             IntrAddr_FL0 !== 32'h0 || IntrFill_FL0 !== 32'h0 || Sum_LD0 !== 32'h0)
            $display("FAIL reset_hold[%0d]: crst/rdy/busy/done=%b addr=%h fill=%h sum=%h want 1000/0/0/0",
                     i, {CoreReset_LD0, ByteRdy_LD0, Busy_LD0, Done_LD0}, IntrAddr_FL0, IntrFill_FL0, Sum_LD0);
         else n_pass++;
      end
      reset = 1'b0;
      tick();
      n_chk++;
      if (ram[0] !== 32'h0) $display("FAIL reset_ram0: got %h want 0", ram[0]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      bit ok;
      int d0;
      d0 = done_pulses;
      start(2);
      for (int i = 0; i < 8; i++) begin
         push_byte(q[i], ok);
         if (i % 4 == 3) begin
            n_chk++;
            if (ByteRdy_LD0 !== 1'b0) $display("FAIL b2b_rdy_low[%0d]: got %b want 0", i, ByteRdy_LD0);
            else n_pass++;
         end
      end
      n_chk++;
      if (CoreReset_LD0 !== 1'b1) $display("FAIL b2b_crst_write: got %b want 1", CoreReset_LD0);
      else n_pass++;
      tick();
      n_chk++;
      if ({Done_LD0, CoreReset_LD0, Busy_LD0} !== 3'b100)
         $display("FAIL b2b_done_entry: done/crst/busy=%b want 100", {Done_LD0, CoreReset_LD0, Busy_LD0});
      else n_pass++;
      n_chk++;
      if (ram[0] !== word_of(q, 0) || ram[1] !== word_of(q, 1))
         $display("FAIL b2b_ram: got %h %h want %h %h", ram[0], ram[1], word_of(q, 0), word_of(q, 1));
      else n_pass++;
      n_chk++;
      if (Sum_LD0 !== 32'hACF13568) $display("FAIL b2b_sum: got %h want acf13568", Sum_LD0);
      else n_pass++;
      tick(); tick();
      n_chk++;
      if (done_pulses - d0 !== 1 || Done_LD0 !== 1'b0)
         $display("FAIL b2b_done_once: pulses=%0d now=%b want 1/0", done_pulses - d0, Done_LD0);
      else n_pass++;
   endtask

   task automatic test_gaps();
      logic [7:0] q[$];
      bit ok;
      int pc;
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      start(1);
      pc = pair_changes;
      for (int i = 0; i < 4; i++) begin
         push_byte(q[i], ok);
         if (i < 3) begin
            n_chk++;
            if (pair_changes !== pc) $display("FAIL gap_midword[%0d]: pair changed %0d times want 0", i, pair_changes - pc);
            else n_pass++;
            tick(); tick();
         end
      end
      wait_done(ok);
      n_chk++;
      if (pair_changes - pc !== 1 || IntrAddr_FL0 !== 32'd0 || ram[0] !== word_of(q, 0))
         $display("FAIL gap_word: changes=%0d addr=%h ram0=%h want 1/0/%h",
                  pair_changes - pc, IntrAddr_FL0, ram[0], word_of(q, 0));
      else n_pass++;
      n_chk++;
      if (Sum_LD0 !== word_of(q, 0)) $display("FAIL gap_sum: got %h want %h", Sum_LD0, word_of(q, 0));
      else n_pass++;
   endtask

   task automatic test_zero_and_saturate();
      logic [7:0] q[$];
      logic [31:0] exp_sum = 0;
      bit ok;
      int pc, bad;
      pc = pair_changes;
      start(0);
      n_chk++;
      if ({Done_LD0, CoreReset_LD0, Busy_LD0} !== 3'b100)
         $display("FAIL zero_done: done/crst/busy=%b want 100", {Done_LD0, CoreReset_LD0, Busy_LD0});
      else n_pass++;
      tick(); tick();
      n_chk++;
      if (pair_changes !== pc) $display("FAIL zero_nowrite: %0d pair changes want 0", pair_changes - pc);
      else n_pass++;

      for (int i = 0; i < 64 * 4; i++) q.push_back(8'($urandom));
      for (int w = 0; w < 64; w++) exp_sum += word_of(q, w);
      start(100);
      pc = pair_changes;
      for (int i = 0; i < 64 * 4; i++) push_byte(q[i], ok);
      wait_done(ok);
      n_chk++;
      if (pair_changes - pc !== 64 || IntrAddr_FL0 !== 32'd63)
         $display("FAIL sat_writes: changes=%0d last_addr=%h want 64/3f", pair_changes - pc, IntrAddr_FL0);
      else n_pass++;
      tick();
      bad = 0;
      for (int w = 0; w < 64; w++) if (ram[w] !== word_of(q, w)) bad++;
      n_chk++;
      if (bad != 0 || Sum_LD0 !== exp_sum)
         $display("FAIL sat_ram_sum: bad_words=%0d sum=%h want 0/%h", bad, Sum_LD0, exp_sum);
      else n_pass++;
   endtask

   task automatic test_start_ignored();
      logic [7:0] q[$];
      bit ok;
      int d0;
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      start(1);
      push_byte(q[0], ok);
      push_byte(q[1], ok);
      start(3);
      n_chk++;
      if (Busy_LD0 !== 1'b1 || ByteRdy_LD0 !== 1'b1)
         $display("FAIL ign_start_state: busy=%b rdy=%b want 1/1", Busy_LD0, ByteRdy_LD0);
      else n_pass++;
      d0 = done_pulses;
      push_byte(q[2], ok);
      push_byte(q[3], ok);
      wait_done(ok);
      n_chk++;
      if (ram[IntrAddr_FL0[5:0]] !== 32'hx && (IntrFill_FL0 !== word_of(q, 0) || IntrAddr_FL0 !== 32'd0))
         $display("FAIL ign_word: addr=%h fill=%h want 0/%h", IntrAddr_FL0, IntrFill_FL0, word_of(q, 0));
      else n_pass++;
      tick();
      n_chk++;
      if (done_pulses - d0 !== 1 || Busy_LD0 !== 1'b0 || ram[0] !== word_of(q, 0))
         $display("FAIL ign_complete: pulses=%0d busy=%b ram0=%h want 1/0/%h",
                  done_pulses - d0, Busy_LD0, ram[0], word_of(q, 0));
      else n_pass++;
   endtask

   task automatic test_reset_midload();
      logic [7:0] q[$];
      logic [31:0] old1;
      bit ok;
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      q[4] = ~ram[1][31:24];
      old1 = ram[1];
      start(2);
      for (int i = 0; i < 6; i++) push_byte(q[i], ok);
      n_chk++;
      if (ram[0] !== word_of(q, 0)) $display("FAIL rst_mid_ram0: got %h want %h", ram[0], word_of(q, 0));
      else n_pass++;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      n_chk++;
      if ({CoreReset_LD0, ByteRdy_LD0, Busy_LD0, Done_LD0} !== 4'b1000 ||
          IntrAddr_FL0 !== 32'h0 || IntrFill_FL0 !== 32'h0 || Sum_LD0 !== 32'h0)
         $display("FAIL rst_mid_outputs: crst/rdy/busy/done=%b addr=%h fill=%h sum=%h want 1000/0/0/0",
                  {CoreReset_LD0, ByteRdy_LD0, Busy_LD0, Done_LD0}, IntrAddr_FL0, IntrFill_FL0, Sum_LD0);
      else n_pass++;
      tick(); tick();
      n_chk++;
      if (ram[1] !== old1 || ByteRdy_LD0 !== 1'b0)
         $display("FAIL rst_mid_ram1: ram1=%h rdy=%b want %h/0", ram[1], ByteRdy_LD0, old1);
      else n_pass++;
   endtask

   initial begin
      reset        = 1'b1;
      Start_LD0    = 1'b0;
      NumWords_LD0 = '0;
      ByteVld_LD0  = 1'b0;
      ByteData_LD0 = '0;
      last_pair    = '0;
      test_reset();
      test_back_to_back();
      test_gaps();
      test_zero_and_saturate();
      test_start_ignored();
      test_reset_midload();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
